mac_rx_pkt_fifo: RTL and testbench

Parametrised store-and-forward receive FIFO between the MAC RX interface and the header buffer; next generation of the byte-wide MAC RX FIFO.
A frame becomes visible downstream only after its last beat is accepted. Frames are discarded whole if the MAC flags an error or the frame overflows storage.
Adds generic data width/depth, frame commit/rewind, a drop counter and a packet-level status.

---
 rtl/mac_rx_pkt_fifo.sv | 231 +++++++++++++++++++++++
 tb/tb_mac_rx_pkt_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_pkt_fifo.sv
// ---------------------------------------------------------------------------
// mac_rx_pkt_fifo
//
// Store-and-forward receive FIFO between the MAC RX interface and the header
// buffer. A frame becomes visible downstream only once its last beat has been
// accepted. Frames flagged bad by the MAC (rx_error with rx_last) or frames
// that overflow storage are discarded whole and counted in drop_cnt.
//
// Three pointers, each ADDR_W+1 bits wide and wrapping naturally:
//   wr_ptr  - speculative write position (current frame in progress)
//   cmt_ptr - end of the last committed frame
//   rd_ptr  - next committed entry to load into the output register
//
// Optional feature macro: MAC_RX_PKT_FIFO_BACKPRESSURE_EN
//   defined   : rx_ready = !full, so storage never overflows (the MAC must
//               bound frame length to DEPTH or the interface stalls forever)
//   undefined : rx_ready = 1, and a beat arriving while full drops the frame
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   rx_valid    in   MAC beat valid
//   rx_data     in   MAC beat data [DATA_W]
//   rx_last     in   final beat of frame
//   rx_error    in   frame bad; only meaningful together with rx_last
//   rx_ready    out  FIFO accepts beat
//   fifo_valid  out  output beat valid (registered)
//   fifo_data   out  output beat data (registered) [DATA_W]
//   fifo_last   out  output final beat (registered)
//   fifo_ready  in   header buffer accepts beat
//   fifo_fire   out  fifo_valid & fifo_ready
//   pkt_avail   out  at least one committed frame not yet fully read
//   level       out  entries used (committed + uncommitted) [ADDR_W+1]
//   drop_cnt    out  frames dropped, saturating [CNT_W]
// ---------------------------------------------------------------------------
module mac_rx_pkt_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_last,
  input  logic              rx_error,
  output logic              rx_ready,
  output logic              fifo_valid,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_last,
  input  logic              fifo_ready,
  output logic              fifo_fire,
  output logic              pkt_avail,
  output logic [ADDR_W:0]   level,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]  PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Each entry carries the beat plus its last flag.
  logic [DATA_W:0]    mem_r [DEPTH];

  state_t             state_r;
  state_t             state_s;
  logic [ADDR_W:0]    wr_ptr_r;
  logic [ADDR_W:0]    cmt_ptr_r;
  logic [ADDR_W:0]    rd_ptr_r;
  logic [ADDR_W:0]    wr_ptr_s;
  logic [ADDR_W:0]    cmt_ptr_s;
  logic               wr_en_s;
  logic               drop_inc_s;
  logic [CNT_W-1:0]   drop_cnt_r;
  logic               fifo_valid_r;
  logic [DATA_W-1:0]  fifo_data_r;
  logic               fifo_last_r;

  logic [ADDR_W:0]    used_s;
  logic               full_s;
  logic               rx_ready_s;
  logic               accept_s;
  logic               overflow_s;
  logic               fire_s;
  logic               load_s;

  assign used_s = wr_ptr_r - rd_ptr_r;
  assign full_s = (used_s == DEPTH_C);

`ifdef MAC_RX_PKT_FIFO_BACKPRESSURE_EN
  assign rx_ready_s = ~full_s;
  assign overflow_s = 1'b0;
`else
  assign rx_ready_s = 1'b1;
  // A beat arriving while storage is full kills the current frame.
  assign overflow_s = rx_valid & full_s & (state_r != ST_DROP);
`endif

  assign accept_s = rx_valid & rx_ready_s;
  assign fire_s   = fifo_valid_r & fifo_ready;
  // Only committed entries (rd_ptr != cmt_ptr) are ever loaded.
  assign load_s   = (~fifo_valid_r | fire_s) & (rd_ptr_r != cmt_ptr_r);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_RECV: begin
        if (overflow_s) begin
          state_s = rx_last ? ST_IDLE : ST_DROP;
        end else if (accept_s) begin
          state_s = rx_last ? ST_IDLE : ST_RECV;
        end else begin
          state_s = state_r;
        end
      end
      ST_DROP: begin
        if (accept_s && rx_last) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: write enable, pointer updates and drop increment.
  // A bad frame rewinds wr_ptr to the pre-edge cmt_ptr; its error beat is
  // simply not written since the rewind would discard it anyway.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_ptr_s   = wr_ptr_r;
    cmt_ptr_s  = cmt_ptr_r;
    drop_inc_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_RECV: begin
        if (overflow_s) begin
          wr_ptr_s   = cmt_ptr_r;
          drop_inc_s = 1'b1;
        end else if (accept_s && rx_last && rx_error) begin
          wr_ptr_s   = cmt_ptr_r;
          drop_inc_s = 1'b1;
        end else if (accept_s) begin
          wr_en_s  = 1'b1;
          wr_ptr_s = wr_ptr_r + PTR_ONE;
          if (rx_last) begin
            cmt_ptr_s = wr_ptr_r + PTR_ONE;
          end else begin
            cmt_ptr_s = cmt_ptr_r;
          end
        end else begin
          wr_ptr_s = wr_ptr_r;
        end
      end
      ST_DROP: begin
        wr_en_s = 1'b0;
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Write-side pointers and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      cmt_ptr_r  <= '0;
      drop_cnt_r <= '0;
    end else begin
      wr_ptr_r  <= wr_ptr_s;
      cmt_ptr_r <= cmt_ptr_s;
      if (drop_inc_s && (drop_cnt_r != CNT_MAX)) begin
        drop_cnt_r <= drop_cnt_r + CNT_ONE;
      end
    end
  end

  // Storage array; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= {rx_last, rx_data};
    end
  end

  // Read pointer and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r     <= '0;
      fifo_valid_r <= 1'b0;
      fifo_data_r  <= '0;
      fifo_last_r  <= 1'b0;
    end else if (load_s) begin
      {fifo_last_r, fifo_data_r} <= mem_r[rd_ptr_r[ADDR_W-1:0]];
      rd_ptr_r     <= rd_ptr_r + PTR_ONE;
      fifo_valid_r <= 1'b1;
    end else if (fire_s) begin
      fifo_valid_r <= 1'b0;
    end
  end

  assign rx_ready   = rx_ready_s;
  assign fifo_valid = fifo_valid_r;
  assign fifo_data  = fifo_data_r;
  assign fifo_last  = fifo_last_r;
  assign fifo_fire  = fire_s;
  assign level      = used_s;
  assign drop_cnt   = drop_cnt_r;
  // Any beat in the output register belongs to a committed frame that has
  // not yet finished firing.
  assign pkt_avail  = (cmt_ptr_r != rd_ptr_r) | fifo_valid_r;

endmodule

// File: tb/tb_mac_rx_pkt_fifo.sv
// ---------------------------------------------------------------------------
// Testbench for mac_rx_pkt_fifo (default build, drop-on-overflow mode).
// A queue-based frame model tracks committed frames, the frame in progress
// and the output register; every cycle the DUT outputs are compared to it.
// A vector table covers the basic 4-beat frame, hand-written sequences cover
// error/overflow/wrap/stall/reset corners, and a random phase follows.
// ---------------------------------------------------------------------------
module tb_mac_rx_pkt_fifo;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_last;
  logic        rx_error;
  logic        rx_ready;
  logic        fifo_valid;
  logic [7:0]  fifo_data;
  logic        fifo_last;
  logic        fifo_ready;
  logic        fifo_fire;
  logic        pkt_avail;
  logic [5:0]  level;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  mac_rx_pkt_fifo #(
    .DATA_W(8), .DEPTH(DEPTH), .ADDR_W(5), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
    .rx_error(rx_error), .rx_ready(rx_ready),
    .fifo_valid(fifo_valid), .fifo_data(fifo_data), .fifo_last(fifo_last),
    .fifo_ready(fifo_ready), .fifo_fire(fifo_fire),
    .pkt_avail(pkt_avail), .level(level), .drop_cnt(drop_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  logic [8:0] cq[$];     // committed beats not yet in the output register
  logic [8:0] pq[$];     // beats of the frame in progress
  logic [8:0] got[$];    // beats observed firing downstream
  logic [8:0] expq[$];   // beats expected downstream for a directed test
  logic       m_valid   = 1'b0;
  logic [7:0] m_data    = 8'h00;
  logic       m_last    = 1'b0;
  int         m_drop    = 0;
  bit         m_in_drop = 1'b0;

  typedef struct {
    logic       rv;
    logic [7:0] rd;
    logic       rl;
    logic       re;
    logic       fr;
    logic       rs;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic [5:0] elv;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_step(input logic rv, input logic [7:0] rd, input logic rl,
                            input logic re, input logic fr, input logic rs);
    int         used;
    bit         fire;
    bit         load;
    logic [8:0] b;
    if (rs) begin
      cq.delete(); pq.delete();
      m_valid = 1'b0; m_data = 8'h00; m_last = 1'b0;
      m_drop = 0; m_in_drop = 1'b0;
      return;
    end
    used = cq.size() + pq.size();
    fire = m_valid && fr;
    load = (!m_valid || fire) && (cq.size() > 0);
    if (load) begin
      b = cq.pop_front();
      m_valid = 1'b1; m_data = b[7:0]; m_last = b[8];
    end else if (fire) begin
      m_valid = 1'b0;
    end
    if (rv) begin
      if (m_in_drop) begin
        if (rl) m_in_drop = 1'b0;
      end else if (used == DEPTH) begin
        pq.delete();
        if (m_drop < 65535) m_drop++;
        if (!rl) m_in_drop = 1'b1;
      end else if (rl && re) begin
        pq.delete();
        if (m_drop < 65535) m_drop++;
      end else begin
        pq.push_back({rl, rd});
        if (rl) begin
          while (pq.size() > 0) cq.push_back(pq.pop_front());
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge comb outputs, step model,
  // then check registered outputs just after the edge.
  task automatic cycle(input logic rv, input logic [7:0] rd, input logic rl,
                       input logic re, input logic fr, input logic rs);
    logic pre_fire;
    rx_valid = rv; rx_data = rd; rx_last = rl; rx_error = re;
    fifo_ready = fr; rst = rs;
    #1;
    if (!rs) begin
      pre_fire = m_valid & fr;
      chk("rx_ready", 32'(rx_ready), 32'd1);
      chk("fifo_fire", 32'(fifo_fire), 32'(pre_fire));
      if (fifo_valid === 1'b1 && fr) got.push_back({fifo_last, fifo_data});
    end
    model_step(rv, rd, rl, re, fr, rs);
    @(posedge clk);
    #1;
    cyc++;
    chk("fifo_valid", 32'(fifo_valid), 32'(m_valid));
    if (m_valid || rs) begin
      chk("fifo_data", 32'(fifo_data), 32'(m_data));
      chk("fifo_last", 32'(fifo_last), 32'(m_last));
    end
    chk("level", 32'(level), 32'(cq.size() + pq.size()));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("pkt_avail", 32'(pkt_avail), 32'((cq.size() > 0) || m_valid));
  endtask

  function automatic logic ready_of(input int mode);
    return (mode == 2) ? cyc[0] : (mode == 1);
  endfunction

  task automatic send_frame(input int n, input logic [7:0] base, input bit err, input int mode);
    for (int i = 0; i < n; i++)
      cycle(1'b1, base + 8'(i), (i == n - 1), err && (i == n - 1), ready_of(mode), 1'b0);
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, ready_of(mode), 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    got.delete();
    expq.delete();
  endtask

  task automatic check_got(input string nm);
    chk({nm, "_count"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      chk(nm, 32'(got[i]), 32'(expq[i]));
    got.delete();
    expq.delete();
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0;
    rx_error = 1'b0; fifo_ready = 1'b0;

    // Basic 4-beat frame: reset, fill, then stream out at one beat per cycle
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 6'd0};
    tbl[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd1};
    tbl[2] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd2};
    tbl[3] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd3};
    tbl[4] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd4};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 6'd3};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 6'd2};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 6'd1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 6'd0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0};
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].rv, tbl[i].rd, tbl[i].rl, tbl[i].re, tbl[i].fr, tbl[i].rs);
      chk("tbl_valid", 32'(fifo_valid), 32'(tbl[i].ev));
      chk("tbl_level", 32'(level), 32'(tbl[i].elv));
      if (tbl[i].ev || tbl[i].rs) begin
        chk("tbl_data", 32'(fifo_data), 32'(tbl[i].ed));
        chk("tbl_last", 32'(fifo_last), 32'(tbl[i].el));
      end
    end
    chk("tbl_drop", 32'(drop_cnt), 32'd0);

    // Good / bad / good frames: only A and C reach the output
    do_reset();
    send_frame(3, 8'hA1, 1'b0, 1);
    send_frame(5, 8'hB1, 1'b1, 1);
    send_frame(2, 8'hC1, 1'b0, 1);
    idle(8, 1);
    expq = '{9'h0A1, 9'h0A2, 9'h1A3, 9'h0C1, 9'h1C2};
    check_got("err_frames");
    chk("err_drop", 32'(drop_cnt), 32'd1);
    chk("err_level", 32'(level), 32'd0);

    // 40-beat frame with output stalled overflows and is dropped once
    do_reset();
    send_frame(40, 8'h00, 1'b0, 0);
    chk("ovf_drop", 32'(drop_cnt), 32'd1);
    chk("ovf_level", 32'(level), 32'd0);
    send_frame(8, 8'h80, 1'b0, 0);
    idle(12, 1);
    for (int i = 0; i < 8; i++) expq.push_back({(i == 7), 8'(8'h80 + i)});
    check_got("ovf_next");
    chk("ovf_drop_end", 32'(drop_cnt), 32'd1);

    // Pointer wrap: 20 frames of 7 beats with fifo_ready toggling
    do_reset();
    for (int f = 0; f < 20; f++) begin
      send_frame(7, 8'(f * 7), 1'b0, 2);
      idle(10, 2);
    end
    idle(30, 2);
    for (int k = 0; k < 140; k++) expq.push_back({(k % 7 == 6), 8'(k)});
    check_got("wrap");
    chk("wrap_drop", 32'(drop_cnt), 32'd0);

    // Output stall holds data/last stable
    do_reset();
    send_frame(3, 8'h50, 1'b0, 0);
    idle(2, 0);
    for (int i = 0; i < 5; i++) begin
      idle(1, 0);
      chk("stall_valid", 32'(fifo_valid), 32'd1);
      chk("stall_data", 32'(fifo_data), 32'h50);
      chk("stall_last", 32'(fifo_last), 32'd0);
    end
    idle(6, 1);
    expq = '{9'h050, 9'h051, 9'h152};
    check_got("stall");

    // Reset in the middle of a frame
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(2, 8'h70, 1'b0, 1);
    idle(6, 1);
    expq = '{9'h070, 9'h171};
    check_got("mid_reset");
    chk("mid_reset_drop", 32'(drop_cnt), 32'd0);

    // Random traffic against the model, including overflow and errors
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic rv, rl, re;
      rv = ($urandom % 10) < 7;
      rl = ($urandom % 6) == 0;
      re = rl && (($urandom % 8) == 0);
      cycle(rv, 8'($urandom), rl, re, 1'($urandom % 2), 1'b0);
    end
    send_frame(1, 8'hEE, 1'b0, 1);
    idle(80, 1);
    chk("rand_level_end", 32'(level), 32'd0);
    chk("rand_valid_end", 32'(fifo_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
